// File: rtl/sound_scheduler.sv
// Sound event scheduler: turns rising edges on four request lines into fixed-length
// square-wave tone bursts, separated by silent gaps and granted by fixed priority (3 highest).
module sound_scheduler #(
  parameter int unsigned DURATION = 12000,
  parameter int unsigned GAP_LEN  = 480,
  parameter int unsigned HP0      = 55,
  parameter int unsigned HP1      = 45,
  parameter int unsigned HP2      = 70,
  parameter int unsigned HP3      = 35,
  parameter logic [31:0] AMP      = 32'h0FFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic        abort,
  input  logic        audio_out_allowed,
  output logic        write_out,
  output logic [31:0] left_out,
  output logic [31:0] right_out,
  output logic        busy,
  output logic [1:0]  active_src,
  output logic [3:0]  pending
);

  localparam logic [15:0] DurLast = 16'(DURATION - 1);
  localparam logic [15:0] GapLast = 16'(GAP_LEN - 1);
  localparam logic [8:0]  Hp0     = 9'(HP0);
  localparam logic [8:0]  Hp1     = 9'(HP1);
  localparam logic [8:0]  Hp2     = 9'(HP2);
  localparam logic [8:0]  Hp3     = 9'(HP3);
  localparam logic [31:0] AmpNeg  = ~AMP + 32'd1;

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  state_e      state_q;
  logic [3:0]  req_q;
  logic [3:0]  pending_q;
  logic [15:0] time_q;
  logic [8:0]  wave_q;
  logic [15:0] gap_q;
  logic        tone_q;
  logic [1:0]  src_q;

  logic [3:0]  req_edge;
  logic        grant;
  logic [1:0]  grant_src;
  logic [3:0]  pending_nxt;
  logic [8:0]  hp;

  assign req_edge = req & ~req_q;

  always_comb begin
    grant_src = 2'd0;
    if (pending_q[3])      grant_src = 2'd3;
    else if (pending_q[2]) grant_src = 2'd2;
    else if (pending_q[1]) grant_src = 2'd1;
    grant = (state_q == StIdle) && (|pending_q);
    // The grant clears the old bit first, so a same-cycle edge re-arms it.
    pending_nxt = (pending_q & ~(grant ? (4'b0001 << grant_src) : 4'b0000)) | req_edge;
  end

  always_comb begin
    case (src_q)
      2'd0:    hp = Hp0;
      2'd1:    hp = Hp1;
      2'd2:    hp = Hp2;
      default: hp = Hp3;
    endcase
  end

  always_ff @(posedge clk) begin
    // Loads during reset too, so a level held across reset release is not an edge.
    req_q <= req;
    if (reset) begin
      state_q   <= StIdle;
      pending_q <= 4'b0000;
      time_q    <= 16'd0;
      wave_q    <= 9'd0;
      gap_q     <= 16'd0;
      tone_q    <= 1'b0;
      src_q     <= 2'd0;
    end else if (abort) begin
      state_q   <= StIdle;
      pending_q <= 4'b0000;
      time_q    <= 16'd0;
      wave_q    <= 9'd0;
      gap_q     <= 16'd0;
      tone_q    <= 1'b0;
    end else begin
      pending_q <= pending_nxt;
      case (state_q)
        StIdle: begin
          if (grant) begin
            state_q <= StPlay;
            src_q   <= grant_src;
            time_q  <= 16'd0;
            wave_q  <= 9'd0;
            tone_q  <= 1'b0;
          end
        end
        StPlay: begin
          if (audio_out_allowed) begin
            if (wave_q == hp) begin
              wave_q <= 9'd0;
              tone_q <= ~tone_q;
            end else begin
              wave_q <= wave_q + 9'd1;
            end
            if (time_q == DurLast) begin
              state_q <= (GAP_LEN == 0) ? StIdle : StGap;
              time_q  <= 16'd0;
              gap_q   <= 16'd0;
            end else begin
              time_q <= time_q + 16'd1;
            end
          end
        end
        StGap: begin
          if (audio_out_allowed) begin
            if (gap_q == GapLast) begin
              state_q <= StIdle;
              gap_q   <= 16'd0;
            end else begin
              gap_q <= gap_q + 16'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign write_out  = (state_q == StPlay) && audio_out_allowed;
  assign left_out   = (state_q != StPlay) ? 32'd0 : (tone_q ? AMP : AmpNeg);
  assign right_out  = left_out;
  assign busy       = (state_q != StIdle);
  assign active_src = src_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_sound_scheduler.sv
// Scoreboard bench for sound_scheduler: expected samples are queued at stimulus time and
// popped by a monitor on every write strobe.
module tb_sound_scheduler;

  localparam logic [31:0] A  = 32'h0FFFFFFF;
  localparam logic [31:0] NA = 32'hF0000001;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic        abort;
  logic        allowed;
  logic        write_out;
  logic [31:0] left_out;
  logic [31:0] right_out;
  logic        busy;
  logic [1:0]  active_src;
  logic [3:0]  pending;

  always #5 clk = ~clk;

  sound_scheduler #(
    .DURATION(8),
    .GAP_LEN (2),
    .HP0     (1),
    .HP3     (2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req              (req),
    .abort            (abort),
    .audio_out_allowed(allowed),
    .write_out        (write_out),
    .left_out         (left_out),
    .right_out        (right_out),
    .busy             (busy),
    .active_src       (active_src),
    .pending          (pending)
  );

  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int silent_busy = 0;
  int cyc = 0;
  int first_strobe = -1;
  int last_strobe = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every strobe consumes one expected sample; silent busy cycles are tallied.
  always @(negedge clk) begin
    logic [31:0] e;
    cyc++;
    if (write_out === 1'b1) begin
      if (first_strobe < 0) first_strobe = cyc;
      last_strobe = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got left_out %h, expected no strobe", left_out);
      end else begin
        e = exp_q.pop_front();
        check("left_out", left_out, e);
        check("right_out", right_out, e);
      end
    end else if (busy === 1'b1) begin
      silent_busy++;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [3:0] m);
    req = req | m;
    step();
    req = req & ~m;
  endtask

  task automatic push_n(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic push_src0();
    exp_q.push_back(NA); exp_q.push_back(NA); exp_q.push_back(A); exp_q.push_back(A);
    exp_q.push_back(NA); exp_q.push_back(NA); exp_q.push_back(A); exp_q.push_back(A);
  endtask

  task automatic push_src3();
    exp_q.push_back(NA); exp_q.push_back(NA); exp_q.push_back(NA); exp_q.push_back(A);
    exp_q.push_back(A);  exp_q.push_back(A);  exp_q.push_back(NA); exp_q.push_back(NA);
  endtask

  // Waits for busy to rise (if not already) and then to fall, with cycle bounds.
  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy !== 1'b1 && k < 20) begin step(); k++; end
    while (busy !== 1'b0 && k < 300) begin step(); k++; end
    if (k >= 300) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy %b, expected 0 within 300 cycles", name, busy);
    end
  endtask

  task automatic wait_strobe(input string name);
    int k;
    k = 0;
    while (write_out !== 1'b1 && k < 50) begin step(); k++; end
    if (k >= 50) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: write_out %b, expected 1 within 50 cycles", name, write_out);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected finish earlier");
    $fatal(1);
  end

  initial begin
    int n;
    int k;
    reset = 1'b1; req = 4'b0000; abort = 1'b0; allowed = 1'b1;
    step(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_write", 32'(write_out), 32'd0);
    check("rst_left", left_out, 32'd0);
    check("rst_right", right_out, 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_src", 32'(active_src), 32'd0);
    reset = 1'b0;
    step(2);

    // Single event from source 0.
    silent_busy = 0;
    push_src0();
    pulse(4'b0001);
    wait_idle("t1");
    check("t1_queue", 32'(exp_q.size()), 32'd0);
    check("t1_gap", 32'(silent_busy), 32'd2);

    // Simultaneous sources 3 and 0: 3 wins.
    silent_busy = 0;
    push_src3();
    push_src0();
    pulse(4'b1001);
    wait_strobe("t2");
    check("t2_pending", 32'(pending), 32'h1);
    check("t2_src", 32'(active_src), 32'd3);
    wait_idle("t2a");
    wait_idle("t2b");
    check("t2_queue", 32'(exp_q.size()), 32'd0);
    check("t2_gap", 32'(silent_busy), 32'd4);

    // Alternating audio_out_allowed.
    push_src0();
    first_strobe = -1;
    req[0] = 1'b1;
    n = 0;
    for (int i = 0; i < 80; i++) begin
      allowed = (i % 2 == 0);
      step();
      if (i == 0) req[0] = 1'b0;
      if (busy === 1'b1) n = 1;
      else if (n == 1) break;
    end
    allowed = 1'b1;
    check("t3_queue", 32'(exp_q.size()), 32'd0);
    check("t3_span", 32'(last_strobe - first_strobe), 32'd14);
    step(2);

    // Abort on the 4th strobe with source 1 pending.
    push_n(NA, 4);
    pulse(4'b0100);
    n = 0;
    k = 0;
    while (n < 4 && k < 50) begin
      @(negedge clk);
      k++;
      if (write_out === 1'b1) begin
        n++;
        if (n == 1) req[1] = 1'b1;
        if (n == 2) req[1] = 1'b0;
      end
    end
    check("t4_strobes", 32'(n), 32'd4);
    check("t4_pending_pre", 32'(pending), 32'h2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_pending", 32'(pending), 32'd0);
    check("t4_write", 32'(write_out), 32'd0);
    step(20);
    check("t4_queue", 32'(exp_q.size()), 32'd0);

    // Request level held across reset release.
    req = 4'b0100;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(20);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_pending", 32'(pending), 32'd0);
    req = 4'b0000;
    step();
    push_n(NA, 8);
    req = 4'b0100;
    wait_idle("t5");
    req = 4'b0000;
    check("t5_queue", 32'(exp_q.size()), 32'd0);

    // Two re-pulses of source 1 during its own event: one replay.
    silent_busy = 0;
    push_n(NA, 16);
    pulse(4'b0010);
    wait_strobe("t6");
    req[1] = 1'b1; step();
    req[1] = 1'b0; step();
    req[1] = 1'b1; step();
    req[1] = 1'b0;
    wait_idle("t6a");
    check("t6_queue_mid", 32'(exp_q.size()), 32'd8);
    wait_idle("t6b");
    step(20);
    check("t6_queue", 32'(exp_q.size()), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_gap", 32'(silent_busy), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sound_scheduler.md
SOUND_SCHEDULER -- requirements
Module: sound_scheduler

Interface
REQ-001 Parameter DURATION, default 12000: audio samples written per sound event.
REQ-002 Parameter GAP_LEN, default 480: silent sample slots inserted after each event.
REQ-003 Parameters HP0/HP1/HP2/HP3, defaults 55/45/70/35: half-period, in samples, of source 0..3 tone (toggle when wave counter equals HPn).
REQ-004 Parameter AMP, default 32'h0FFFFFFF: positive square-wave level; negative level is its two's complement (32'hF0000001).
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port req, input, 4: level event requests from game logic; the rising edge of bit n is a request from source n.
REQ-008 Port abort, input, 1: synchronous cancel of current and pending sounds.
REQ-009 Port audio_out_allowed, input, 1: CODEC output FIFO has space; marks one sample slot.
REQ-010 Port write_out, output, 1: sample write strobe to CODEC.
REQ-011 Port left_out, output, 32: left sample.
REQ-012 Port right_out, output, 32: right sample, always equal to left_out.
REQ-013 Port busy, output, 1: high when state is not IDLE.
REQ-014 Port active_src, output, 2: source currently playing or in gap.
REQ-015 Port pending, output, 4: registered pending-request bits.

Function
REQ-016 Edge detect: req_d registers req every cycle; edge[n] = req[n] & ~req_d[n].
REQ-017 Edge on source n sets pending[n] the next cycle; an edge on an already-pending source has no further effect (no counting).
REQ-018 Edge on the currently playing source sets its pending bit, so it replays after the current event.
REQ-019 States: IDLE, PLAY, GAP; encoding free.
REQ-020 IDLE with any pending bit: next cycle enter PLAY, active_src = highest-index pending bit (fixed priority, 3 highest), that bit cleared, time_cnt=0, wave_cnt=0, tone_state=0.
REQ-021 Same-cycle edge on the source being granted: grant clears the old bit and the edge sets it again (pending[n]=1 after the grant).
REQ-022 PLAY, on each cycle with audio_out_allowed=1: time_cnt increments; wave_cnt increments, or wraps to 0 and toggles tone_state when wave_cnt == HP[active_src]; cycles with audio_out_allowed=0 hold all counters.
REQ-023 PLAY exits to GAP on the allowed cycle where time_cnt == DURATION-1, so exactly DURATION strobes per event; if GAP_LEN=0 it exits directly to IDLE.
REQ-024 GAP counts GAP_LEN allowed cycles with write_out=0, then enters IDLE; no preemption in PLAY or GAP.
REQ-025 write_out = (state==PLAY) & audio_out_allowed, combinational.
REQ-026 left_out = AMP when PLAY and tone_state=1; two's-complement -AMP when PLAY and tone_state=0; 0 otherwise.
REQ-027 abort=1: next cycle state=IDLE, pending=0, counters=0; edges in the same cycle are discarded; abort in IDLE only clears pending.
REQ-028 Counters sized for parameter maxima (time 16 bit, wave 9 bit, gap 16 bit); no overflow for legal parameters.

Reset
REQ-029 reset=1 forces, next edge: state=IDLE, pending=0, time_cnt=wave_cnt=gap_cnt=0, tone_state=0, active_src=0; outputs busy=0, write_out=0, left_out=right_out=0.
REQ-030 During reset req_d loads req, so a req level held high across reset release produces no edge.
REQ-031 Reset mid-PLAY ends the event with no further strobes; reset has priority over abort and edges.

Verification (bench overrides DURATION=8, GAP_LEN=2, HP0=1, HP3=2)
REQ-032 req[0] pulse, audio_out_allowed=1 continuous -> exactly 8 write_out strobes, left_out pattern -A,-A,+A,+A,-A,-A,+A,+A, then 2 silent cycles, busy low.
REQ-033 req[0] and req[3] rise same cycle -> source 3 plays first (period 6 samples), then source 0; 16 strobes total; pending shows 4'b0001 during the first event.
REQ-034 audio_out_allowed toggling 1,0 -> 8 strobes across 16 cycles; tone phase advances only on allowed cycles.
REQ-035 abort at 4th strobe with pending=4'b0010 -> no further strobes, pending=0, busy=0 next cycle.
REQ-036 req[2] held high through reset release -> no sound; after req[2] falls and rises -> one event.
REQ-037 req[1] re-pulsed twice during its own PLAY -> exactly one replay follows.
